logo_motion_ctrl: RTL and testbench

LOGO_MOTION_CTRL -- requirements
Module: logo_motion_ctrl

---
 rtl/logo_motion_if.sv | 23 ++
 rtl/logo_motion_ctrl.sv | 104 ++++++++++
 tb/tb_logo_motion_ctrl.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/logo_motion_if.sv
// logo_motion_if: bundles the scanline input, motion controls and logo position/status outputs
// master drives vpos/pause/speed and observes the logo state; slave is the motion controller.
interface logo_motion_if;
  logic [9:0] vpos;
  logic       pause;
  logic [1:0] speed;
  logic [9:0] logo_left;
  logic [9:0] logo_top;
  logic       dir_x;
  logic       dir_y;
  logic [2:0] color_index;
  logic       bounce;
  logic       corner;
  logic       busy;
  modport master (
    output vpos, pause, speed,
    input  logo_left, logo_top, dir_x, dir_y, color_index, bounce, corner, busy
  );
  modport slave (
    input  vpos, pause, speed,
    output logo_left, logo_top, dir_x, dir_y, color_index, bounce, corner, busy
  );
endinterface

// File: rtl/logo_motion_ctrl.sv
// logo_motion_ctrl: once per frame moves a bouncing logo one X step then one Y step, counting wall hits
// Ports: clk pixel clock; rst_n async active-low reset; bus (slave) carries vpos/pause/speed in,
// logo_left/logo_top/dir_x/dir_y/color_index/bounce/corner/busy out.
module logo_motion_ctrl #(
  parameter int LOGO_SIZE      = 128,
  parameter int DISPLAY_WIDTH  = 640,
  parameter int DISPLAY_HEIGHT = 480,
  parameter int START_X        = 200,
  parameter int START_Y        = 200
) (
  input  logic          clk,
  input  logic          rst_n,
  logo_motion_if.slave  bus
);
  localparam logic [10:0] X_LIM = 11'(DISPLAY_WIDTH - LOGO_SIZE);
  localparam logic [10:0] Y_LIM = 11'(DISPLAY_HEIGHT - LOGO_SIZE);
  typedef enum logic [1:0] {IDLE, MOVE_X, MOVE_Y, DONE} state_t;
  state_t      state_q, state_d;
  logic [9:0]  prev_vpos_q;
  logic [9:0]  left_q, left_d, top_q, top_d;
  logic        dir_x_q, dir_x_d, dir_y_q, dir_y_d;
  logic        hit_x_q, hit_x_d, hit_y_q, hit_y_d;
  logic [2:0]  color_q, color_d, step_q, step_d;
  logic        frame_tick, x_wall, y_wall;
  logic [10:0] x_sum, y_sum;
  logic [9:0]  x_next, y_next;
  assign frame_tick = bus.vpos == 10'd0 && prev_vpos_q != 10'd0;
  // Wall tests run in 11 bits so left+step can never wrap past the limit.
  assign x_sum  = {1'b0, left_q} + {8'b0, step_q};
  assign y_sum  = {1'b0, top_q} + {8'b0, step_q};
  assign x_wall = dir_x_q ? x_sum >= X_LIM : {1'b0, left_q} <= {8'b0, step_q};
  assign y_wall = dir_y_q ? y_sum >= Y_LIM : {1'b0, top_q} <= {8'b0, step_q};
  assign x_next = dir_x_q ? left_q + {7'b0, step_q} : left_q - {7'b0, step_q};
  assign y_next = dir_y_q ? top_q + {7'b0, step_q} : top_q - {7'b0, step_q};
  always_comb begin
    state_d = state_q;
    left_d  = left_q;
    top_d   = top_q;
    dir_x_d = dir_x_q;
    dir_y_d = dir_y_q;
    hit_x_d = hit_x_q;
    hit_y_d = hit_y_q;
    color_d = color_q;
    step_d  = step_q;
    case (state_q)
      IDLE: if (frame_tick && !bus.pause) begin
        state_d = MOVE_X;
        step_d  = {1'b0, bus.speed} + 3'd1;
      end
      MOVE_X: begin
        state_d = MOVE_Y;
        left_d  = x_wall ? (dir_x_q ? X_LIM[9:0] : 10'd0) : x_next;
        dir_x_d = dir_x_q ^ x_wall;
        hit_x_d = x_wall;
      end
      MOVE_Y: begin
        state_d = DONE;
        top_d   = y_wall ? (dir_y_q ? Y_LIM[9:0] : 10'd0) : y_next;
        dir_y_d = dir_y_q ^ y_wall;
        hit_y_d = y_wall;
      end
      DONE: begin
        state_d = IDLE;
        color_d = color_q + {2'b0, hit_x_q | hit_y_q};
        hit_x_d = 1'b0;
        hit_y_d = 1'b0;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      prev_vpos_q <= '0;
      left_q      <= 10'(START_X);
      top_q       <= 10'(START_Y);
      dir_x_q     <= 1'b1;
      dir_y_q     <= 1'b0;
      hit_x_q     <= 1'b0;
      hit_y_q     <= 1'b0;
      color_q     <= '0;
      step_q      <= 3'd1;
    end else begin
      state_q     <= state_d;
      prev_vpos_q <= bus.vpos;
      left_q      <= left_d;
      top_q       <= top_d;
      dir_x_q     <= dir_x_d;
      dir_y_q     <= dir_y_d;
      hit_x_q     <= hit_x_d;
      hit_y_q     <= hit_y_d;
      color_q     <= color_d;
      step_q      <= step_d;
    end
  end
  assign bus.logo_left   = left_q;
  assign bus.logo_top    = top_q;
  assign bus.dir_x       = dir_x_q;
  assign bus.dir_y       = dir_y_q;
  assign bus.color_index = color_q;
  assign bus.busy        = state_q != IDLE;
  assign bus.bounce      = state_q == DONE && (hit_x_q || hit_y_q);
  assign bus.corner      = state_q == DONE && hit_x_q && hit_y_q;
endmodule

// File: tb/tb_logo_motion_ctrl.sv
// tb_logo_motion_ctrl: directed frames with a queued expectation per update, checked by a monitor
module tb_logo_motion_ctrl;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  logo_motion_if bus ();
  logo_motion_if bus2 ();
  logo_motion_ctrl dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  logo_motion_ctrl #(.START_X(511), .START_Y(1)) dut2 (.clk(clk), .rst_n(rst_n), .bus(bus2));
  typedef struct {int left; int top; int dx; int dy; int col; int bnc; int cor;} exp_t;
  exp_t q[$];
  exp_t e_m;
  int errors = 0, checks = 0, updates = 0;
  int m_left = 200, m_top = 200, m_dx = 1, m_dy = 0, m_col = 0;
  int run = 0, nb = 0, nc = 0;
  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask
  task automatic model_reset();
    m_left = 200; m_top = 200; m_dx = 1; m_dy = 0; m_col = 0;
  endtask
  task automatic push_model(input int stp);
    exp_t e;
    int hx, hy;
    hx = 0; hy = 0;
    if (m_dx == 1) begin
      if (m_left + stp >= 512) begin m_left = 512; m_dx = 0; hx = 1; end
      else m_left = m_left + stp;
    end else begin
      if (m_left <= stp) begin m_left = 0; m_dx = 1; hx = 1; end
      else m_left = m_left - stp;
    end
    if (m_dy == 1) begin
      if (m_top + stp >= 352) begin m_top = 352; m_dy = 0; hy = 1; end
      else m_top = m_top + stp;
    end else begin
      if (m_top <= stp) begin m_top = 0; m_dy = 1; hy = 1; end
      else m_top = m_top - stp;
    end
    if (hx == 1 || hy == 1) m_col = (m_col + 1) % 8;
    e.left = m_left; e.top = m_top; e.dx = m_dx; e.dy = m_dy; e.col = m_col;
    e.bnc = (hx == 1 || hy == 1) ? 1 : 0;
    e.cor = (hx == 1 && hy == 1) ? 1 : 0;
    q.push_back(e);
  endtask
  // Monitor: an update is complete when busy falls; compare against the oldest expectation.
  always @(negedge clk) begin
    if (!rst_n) begin
      run = 0; nb = 0; nc = 0;
    end else if (bus.busy) begin
      run++; nb += int'(bus.bounce); nc += int'(bus.corner);
    end else if (run > 0) begin
      updates++;
      if (q.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_update: got left=%0d top=%0d expected no update", bus.logo_left, bus.logo_top);
      end else begin
        e_m = q.pop_front();
        chk("busy_cycles", run, 3);
        chk("left", int'(bus.logo_left), e_m.left);
        chk("top", int'(bus.logo_top), e_m.top);
        chk("dir_x", int'(bus.dir_x), e_m.dx);
        chk("dir_y", int'(bus.dir_y), e_m.dy);
        chk("color", int'(bus.color_index), e_m.col);
        chk("bounce_pulses", nb, e_m.bnc);
        chk("corner_pulses", nc, e_m.cor);
      end
      run = 0; nb = 0; nc = 0;
    end
  end
  task automatic step_clk(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  // Leaves the DUT in MOVE_X, one step after the edge that saw the tick.
  task automatic tick();
    bus.vpos = 10'd524;
    step_clk(1);
    bus.vpos = 10'd0;
    step_clk(1);
  endtask
  task automatic frame(input int spd);
    bus.speed = 2'(spd);
    push_model(spd + 1);
    tick();
    step_clk(5);
  endtask
  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end
  initial begin
    int u0, bh, nb2, nc2;
    bus.vpos = 10'd0; bus.pause = 1'b0; bus.speed = 2'd0;
    bus2.vpos = 10'd0; bus2.pause = 1'b0; bus2.speed = 2'd0;
    step_clk(2);
    chk("rst_left", int'(bus.logo_left), 200);
    chk("rst_top", int'(bus.logo_top), 200);
    chk("rst_dir_x", int'(bus.dir_x), 1);
    chk("rst_dir_y", int'(bus.dir_y), 0);
    chk("rst_color", int'(bus.color_index), 0);
    chk("rst_busy", int'(bus.busy), 0);
    chk("rst_bounce", int'(bus.bounce), 0);
    chk("rst_corner", int'(bus.corner), 0);
    rst_n = 1'b1;
    step_clk(10);
    chk("no_tick_from_reset_zero", updates, 0);
    // First frame at speed 0; speed and pause changed mid-sequence must not matter.
    push_model(1);
    tick();
    bus.speed = 2'd3;
    bus.pause = 1'b1;
    step_clk(5);
    chk("f1_left", int'(bus.logo_left), 201);
    chk("f1_top", int'(bus.logo_top), 199);
    chk("f1_color", int'(bus.color_index), 0);
    // Paused tick: nothing moves.
    bus.speed = 2'd0;
    tick();
    bh = 0;
    repeat (5) begin step_clk(1); bh += int'(bus.busy); end
    chk("pause_busy", bh, 0);
    chk("pause_left", int'(bus.logo_left), 201);
    chk("pause_top", int'(bus.logo_top), 199);
    bus.pause = 1'b0;
    frame(0);
    chk("after_pause_left", int'(bus.logo_left), 202);
    // vpos held at 0 with a 0->1->0 glitch while busy: one update only.
    u0 = updates;
    push_model(1);
    tick();
    bus.vpos = 10'd1;
    step_clk(1);
    bus.vpos = 10'd0;
    step_clk(1000);
    chk("hold_updates", updates - u0, 1);
    chk("hold_left", int'(bus.logo_left), 203);
    chk("hold_top", int'(bus.logo_top), 197);
    // Reset during MOVE_Y discards the partial update immediately.
    u0 = updates;
    tick();
    step_clk(1);
    rst_n = 1'b0;
    #1;
    chk("async_rst_left", int'(bus.logo_left), 200);
    chk("async_rst_top", int'(bus.logo_top), 200);
    chk("async_rst_busy", int'(bus.busy), 0);
    chk("async_rst_dir_x", int'(bus.dir_x), 1);
    step_clk(3);
    rst_n = 1'b1;
    model_reset();
    step_clk(10);
    chk("no_update_after_reset", updates - u0, 0);
    frame(0);
    chk("post_rst_left", int'(bus.logo_left), 201);
    chk("post_rst_top", int'(bus.logo_top), 199);
    // Long run at speed 3 from the reset position.
    rst_n = 1'b0;
    step_clk(2);
    rst_n = 1'b1;
    model_reset();
    for (int f = 1; f <= 78; f++) begin
      frame(3);
      if (f == 50) begin
        chk("f50_top", int'(bus.logo_top), 0);
        chk("f50_dir_y", int'(bus.dir_y), 1);
        chk("f50_color", int'(bus.color_index), 1);
      end
      if (f == 78) begin
        chk("f78_left", int'(bus.logo_left), 512);
        chk("f78_dir_x", int'(bus.dir_x), 0);
        chk("f78_color", int'(bus.color_index), 2);
      end
    end
    // Corner hit on the second instance.
    bus2.vpos = 10'd524;
    step_clk(1);
    bus2.vpos = 10'd0;
    step_clk(1);
    nb2 = 0; nc2 = 0;
    repeat (5) begin
      nb2 += int'(bus2.bounce); nc2 += int'(bus2.corner);
      step_clk(1);
    end
    chk("corner_bounce_pulses", nb2, 1);
    chk("corner_pulses", nc2, 1);
    chk("corner_left", int'(bus2.logo_left), 512);
    chk("corner_top", int'(bus2.logo_top), 0);
    chk("corner_color", int'(bus2.color_index), 1);
    for (int i = 0; i < 20 && q.size() != 0; i++) step_clk(1);
    chk("queue_drained", q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
